// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: the dcache and the icache share one RAM port, and the dcache
// has fixed priority. It reports a sticky bus error on a RAM ERROR or on a grant timeout.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        bus_error
);

  localparam logic [1:0]  RAM_ACCESS = 2'd2;
  localparam logic [1:0]  RAM_ERROR  = 2'd3;
  localparam logic [31:0] BAD_WORD   = 32'hBAD1BAD1;
  localparam logic [6:0]  CNT_LAST   = 7'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT, ERRDONE} state_t;

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [31:0] store_reg;
  logic        wen_reg;
  logic        dside_reg;
  logic [6:0]  cnt_reg;
  logic        bus_error_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      store_reg     <= '0;
      wen_reg       <= 1'b0;
      dside_reg     <= 1'b0;
      cnt_reg       <= '0;
      bus_error_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (dREN || dWEN) begin
            state_reg <= DGRANT;
            addr_reg  <= daddr;
            store_reg <= dstore;
            wen_reg   <= dWEN;
            dside_reg <= 1'b1;
            cnt_reg   <= '0;
          end else if (iREN) begin
            state_reg <= IGRANT;
            addr_reg  <= iaddr;
            store_reg <= '0;
            wen_reg   <= 1'b0;
            dside_reg <= 1'b0;
            cnt_reg   <= '0;
          end
        end
        DGRANT, IGRANT: begin
          if (ramstate == RAM_ACCESS) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 7'd1;
            // cnt_reg counts the non-ACCESS cycles already spent, so this is the last allowed one
            if (ramstate == RAM_ERROR || cnt_reg == CNT_LAST) begin
              state_reg     <= ERRDONE;
              bus_error_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic granted;
  logic done;
  logic errdone;

  always_comb begin
    granted = (state_reg == DGRANT) || (state_reg == IGRANT);
    done    = granted && (ramstate == RAM_ACCESS);
    errdone = (state_reg == ERRDONE);

    ramREN   = granted && !wen_reg;
    ramWEN   = granted && wen_reg;
    ramaddr  = granted ? addr_reg : '0;
    ramstore = granted ? store_reg : '0;

    dwait = !((done || errdone) && dside_reg);
    iwait = !((done || errdone) && !dside_reg);
    dload = (done && dside_reg) ? ramload : BAD_WORD;
    iload = (done && !dside_reg) ? ramload : BAD_WORD;

    bus_error = bus_error_reg;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: read, contention, write, RAM error, reset abort
// and timeout, with expected values written out by hand.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        bus_error;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0]  FREE   = 2'd0;
  localparam logic [1:0]  BUSY   = 2'd1;
  localparam logic [1:0]  ACCESS = 2'd2;
  localparam logic [1:0]  ERROR  = 2'd3;
  localparam logic [31:0] BAD    = 32'hBAD1BAD1;

  mem_arbiter #(.TIMEOUT_CYCLES(64)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .bus_error(bus_error)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then changed and checked mid-cycle.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = FREE;
    #12;
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_iload", iload, BAD);
    chk("rst_dload", dload, BAD);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    tick();
    RST = 1'b0;

    // Read: two BUSY cycles, then ACCESS on the third grant cycle
    dREN = 1; daddr = 32'h40; #1;
    $display("txn read  daddr=%h", daddr);
    chk("rd_arb_ramREN", 32'(ramREN), 32'd0);
    tick(); ramstate = BUSY; #1;
    chk("rd_g1_ramREN", 32'(ramREN), 32'd1);
    chk("rd_g1_ramaddr", ramaddr, 32'h40);
    chk("rd_g1_dwait", 32'(dwait), 32'd1);
    tick(); #1;
    chk("rd_g2_ramaddr", ramaddr, 32'h40);
    chk("rd_g2_dload", dload, BAD);
    tick(); ramstate = ACCESS; ramload = 32'h1234; #1;
    chk("rd_g3_ramaddr", ramaddr, 32'h40);
    chk("rd_g3_dwait", 32'(dwait), 32'd0);
    chk("rd_g3_dload", dload, 32'h1234);
    chk("rd_g3_iwait", 32'(iwait), 32'd1);
    tick(); dREN = 0; ramstate = FREE; #1;
    chk("rd_idle_dwait", 32'(dwait), 32'd1);
    chk("rd_idle_ramREN", 32'(ramREN), 32'd0);
    chk("rd_idle_dload", dload, BAD);

    // Contention: dcache first, one IDLE bubble, then icache
    dREN = 1; daddr = 32'h80; iREN = 1; iaddr = 32'h200; #1;
    $display("txn contention daddr=%h iaddr=%h", daddr, iaddr);
    tick(); ramstate = ACCESS; ramload = 32'h11; #1;
    chk("ct_d_ramaddr", ramaddr, 32'h80);
    chk("ct_d_dwait", 32'(dwait), 32'd0);
    chk("ct_d_iwait", 32'(iwait), 32'd1);
    tick(); dREN = 0; ramstate = FREE; #1;
    chk("ct_bubble_iwait", 32'(iwait), 32'd1);
    chk("ct_bubble_ramREN", 32'(ramREN), 32'd0);
    tick(); ramstate = ACCESS; ramload = 32'h22; #1;
    chk("ct_i_ramaddr", ramaddr, 32'h200);
    chk("ct_i_ramREN", 32'(ramREN), 32'd1);
    chk("ct_i_iwait", 32'(iwait), 32'd0);
    chk("ct_i_iload", iload, 32'h22);
    chk("ct_i_dwait", 32'(dwait), 32'd1);
    chk("ct_i_dload", dload, BAD);
    tick(); iREN = 0; ramstate = FREE; #1;

    // Write with both enables; cache inputs change mid-grant
    dWEN = 1; dREN = 1; daddr = 32'h3100; dstore = 32'hCAFE; #1;
    $display("txn write daddr=%h dstore=%h", daddr, dstore);
    tick(); daddr = 32'h9999; dstore = 32'h0; ramstate = BUSY; #1;
    chk("wr_ramWEN", 32'(ramWEN), 32'd1);
    chk("wr_ramREN", 32'(ramREN), 32'd0);
    chk("wr_ramaddr", ramaddr, 32'h3100);
    chk("wr_ramstore", ramstore, 32'hCAFE);
    tick(); ramstate = ACCESS; ramload = 32'h5; #1;
    chk("wr_done_ramaddr", ramaddr, 32'h3100);
    chk("wr_done_dwait", 32'(dwait), 32'd0);
    chk("wr_done_dload", dload, 32'h5);
    tick(); dWEN = 0; dREN = 0; ramstate = FREE; #1;
    chk("wr_bus_error", 32'(bus_error), 32'd0);

    // RAM ERROR on an icache grant
    iREN = 1; iaddr = 32'h44; #1;
    $display("txn ierror iaddr=%h", iaddr);
    tick(); ramstate = ERROR; #1;
    chk("er_grant_iwait", 32'(iwait), 32'd1);
    chk("er_grant_ramREN", 32'(ramREN), 32'd1);
    tick(); iREN = 0; ramstate = FREE; #1;
    chk("er_done_iwait", 32'(iwait), 32'd0);
    chk("er_done_iload", iload, BAD);
    chk("er_done_ramREN", 32'(ramREN), 32'd0);
    chk("er_done_dwait", 32'(dwait), 32'd1);
    chk("er_done_bus_error", 32'(bus_error), 32'd1);
    tick(); #1;
    chk("er_idle_iwait", 32'(iwait), 32'd1);
    chk("er_sticky_bus_error", 32'(bus_error), 32'd1);

    // Reset in the middle of a dcache grant
    dREN = 1; daddr = 32'h10; #1;
    $display("txn reset-abort daddr=%h", daddr);
    tick(); ramstate = BUSY; #1;
    chk("ra_grant_ramREN", 32'(ramREN), 32'd1);
    RST = 1; dREN = 0; #1;
    chk("ra_ramREN", 32'(ramREN), 32'd0);
    chk("ra_ramaddr", ramaddr, 32'd0);
    chk("ra_dwait", 32'(dwait), 32'd1);
    chk("ra_bus_error", 32'(bus_error), 32'd0);
    tick(); RST = 0; ramstate = FREE; #1;
    tick(); #1;
    chk("ra_idle_ramREN", 32'(ramREN), 32'd0);
    chk("ra_idle_dwait", 32'(dwait), 32'd1);

    // Timeout: RAM stays BUSY for 64 granted cycles
    dREN = 1; daddr = 32'h50; #1;
    $display("txn timeout daddr=%h", daddr);
    tick(); dREN = 0; ramstate = BUSY; #1;
    for (int k = 1; k <= 64; k++) begin
      chk($sformatf("to_c%0d_dwait", k), 32'(dwait), 32'd1);
      chk($sformatf("to_c%0d_ramREN", k), 32'(ramREN), 32'd1);
      if (k == 64) chk("to_c64_bus_error", 32'(bus_error), 32'd0);
      tick();
    end
    chk("to_done_dwait", 32'(dwait), 32'd0);
    chk("to_done_dload", dload, BAD);
    chk("to_done_ramREN", 32'(ramREN), 32'd0);
    chk("to_done_bus_error", 32'(bus_error), 32'd1);
    ramstate = FREE;
    tick(); tick(); #1;
    chk("to_idle_dwait", 32'(dwait), 32'd1);
    chk("to_sticky_bus_error", 32'(bus_error), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, the maximum granted cycles without RAM ACCESS before a bus error is declared.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports iREN, input, 1 and iaddr, input, 32: the icache read request.
REQ-005 SHALL have ports iwait, output, 1 and iload, output, 32: the icache response.
REQ-006 SHALL have ports dREN, input, 1; dWEN, input, 1; daddr, input, 32; dstore, input, 32: the dcache request.
REQ-007 SHALL have ports dwait, output, 1 and dload, output, 32: the dcache response.
REQ-008 SHALL have ports ramREN, output, 1; ramWEN, output, 1; ramaddr, output, 32; ramstore, output, 32: the RAM command.
REQ-009 SHALL have ports ramload, input, 32 and ramstate, input, 2 (FREE=0, BUSY=1, ACCESS=2, ERROR=3): the RAM response.
REQ-010 SHALL have port bus_error, output, 1, a sticky error flag.

Function
REQ-011 SHALL implement states IDLE, DGRANT, IGRANT and ERRDONE.
REQ-012 IDLE: if dREN or dWEN is high, SHALL go to DGRANT; else if iREN is high, SHALL go to IGRANT; else SHALL stay in IDLE. The dcache always has priority.
REQ-013 On leaving IDLE, SHALL register the winner's address, store data and op (a write when dWEN is high, a read otherwise); dWEN and dREN together SHALL be treated as a write.
REQ-014 In DGRANT and IGRANT, SHALL drive ramaddr, ramstore, ramREN and ramWEN from the registered request only; later changes on the cache inputs SHALL be ignored.
REQ-015 In IDLE, ramREN and ramWEN SHALL be 0, and ramaddr and ramstore SHALL be 0.
REQ-016 iwait and dwait SHALL default to 1. In the cycle ramstate==ACCESS, the granted side's wait SHALL be 0 for exactly that cycle, and the next state SHALL be IDLE.
REQ-017 dload and iload SHALL default to 32'hBAD1BAD1. In the completing cycle, the granted side's load SHALL combinationally equal ramload; on a write, ramload is still passed through.
REQ-018 Minimum latency, request to completion, SHALL be 2 cycles: one IDLE arbitration cycle, then the grant cycle with RAM ACCESS.
REQ-019 There SHALL always be one IDLE bubble between transactions, so a cache has a cycle to present its next address. A two-word dcache block therefore takes at least 4 cycles.
REQ-020 A 7-bit wait counter SHALL clear on entry to a grant state and increment each granted cycle that ramstate!=ACCESS.
REQ-021 ramstate==ERROR, or the counter reaching TIMEOUT_CYCLES, SHALL move the FSM to ERRDONE.
REQ-022 ERRDONE SHALL last one cycle: granted side's wait=0, its load=32'hBAD1BAD1, RAM enables 0, bus_error set; then the FSM SHALL return to IDLE.
REQ-023 bus_error SHALL stay 1 until reset.
REQ-024 The non-granted side's wait SHALL remain 1 throughout, however long it is starved.
REQ-025 If a cache drops its request mid-grant, the transaction SHALL still complete to the RAM. Its wait pulse SHALL still be issued and is ignored by the cache.

Reset
REQ-026 RST high SHALL asynchronously force: state=IDLE, registered request=0, counter=0, bus_error=0, ramREN=ramWEN=0, iwait=dwait=1, iload=dload=32'hBAD1BAD1.
REQ-027 RST asserted mid-grant SHALL abort the RAM command immediately, with no completion pulse.
REQ-028 After RST falls, arbitration SHALL begin on the first rising edge.

Verification
REQ-029 Read: dREN=1, daddr=0x40, RAM returns ACCESS 3 cycles after grant with ramload=0x1234 -> dwait=0 for one cycle with dload=0x1234; ramaddr=0x40 held for 3 cycles.
REQ-030 Contention: iREN and dREN rise on the same cycle -> dcache is served first; iwait stays 1 until the dcache completes plus the IDLE bubble; then the icache is served.
REQ-031 Write: dWEN=dREN=1, daddr=0x3100, dstore=0xCAFE -> ramWEN=1, ramREN=0, ramstore=0xCAFE; changing daddr mid-grant leaves ramaddr=0x3100.
REQ-032 Timeout: ramstate held at BUSY -> after 64 granted cycles, ERRDONE; dwait=0 with dload=0xBAD1BAD1; bus_error=1 and stays 1.
REQ-033 ERROR: ramstate=ERROR on an icache grant -> iwait=0 with iload=0xBAD1BAD1 the next cycle; bus_error=1.
REQ-034 Reset: RST pulsed during a dcache grant -> ramREN drops within the same cycle; no dwait pulse; state=IDLE.
